mux_16b_two_input: RTL and testbench
====================================

// Module: mux_16b_two_input
// PURPOSE
//  - Word-wide 2:1 selector for the accumulator datapath (ALU operand / writeback source select).
//  - Combinational path: Output follows A or B, chosen by Op, with zero latency.
//  - Registered copy Output_q gives a one-cycle pipelined version for timing-critical consumers.
//  - Clock and reset affect only Output_q; the combinational path ignores them.
// PARAMETERS
//  - WIDTH        16   data width of A, B, Output, Output_q
//  - RESET_VALUE  0    value loaded into Output_q while reset is high (WIDTH bits)
// PORTS
//  - clk       in   1      single clock, rising-edge active; used only by Output_q
//  - reset     in   1      asynchronous, active-high reset; clears Output_q only
//  - A         in   WIDTH  data input selected when Op = 0
//  - B         in   WIDTH  data input selected when Op = 1
//  - Op        in   1      select: 0 -> A, 1 -> B
//  - Output    out  WIDTH  combinational mux result
//  - Output_q  out  WIDTH  registered mux result
// BEHAVIOUR
//  - Output = Op ? B : A; purely combinational, no latches.
//  - Output re-evaluates on any change of A, B or Op.
//  - Output is independent of clk and reset, including while reset is held high.
//  - Op is treated as 2-state: any value other than 1 selects A.
//  - Output_q reset: goes to RESET_VALUE immediately when reset rises, without waiting for a clock edge.
//  - Output_q holds RESET_VALUE for as long as reset is high.
//  - Output_q normal operation: on each rising clk edge with reset low, Output_q <= (Op ? B : A).
//  - Latency: Output = 0 cycles; Output_q = 1 cycle.
//  - Reset deassertion: the first rising edge after reset falls loads the current selection.
//  - Reset mid-operation: Output_q clears at once; Output keeps tracking its inputs.
//  - Simultaneous edge and input change: Output_q captures the values present before the edge.
//  - No arithmetic, truncation or sign handling: bits pass unchanged.
//  - Full range 0..2^WIDTH-1 is supported.
//  - No handshake and no state machine; Output_q is the only storage.
// TESTING
//  - A=57, B=10034, Op=0, settle 100 ns -> Output==57.
//  - Op 0->1, wait 20 ns -> Output==10034.
//  - reset=1 at any time -> Output_q==0 immediately while Output still == selected input.
//  - reset=0, Op=1, B=10034, one rising clk -> Output_q==10034; then Op=0, next edge -> Output_q==57.
//  - Op=1, change A 57->0xFFFF -> Output stays 10034; B->0x0000 -> Output==0x0000.
//  - Boundary: A=0xFFFF, B=0x0000, toggle Op each cycle -> Output/Output_q alternate with no bit loss.

Source files
------------

// File: rtl/mux_16b_two_input.sv
// Word-wide 2:1 select for the accumulator datapath.
// Combinational result plus a one-cycle registered copy.
module mux_16b_two_input #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Op,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Output_q
);

  logic [WIDTH-1:0] sel;

  // Anything but a clean 1 on Op falls through to A.
  always_comb begin
    sel = A;
    if (Op == 1'b1) sel = B;
  end

  assign Output = sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) Output_q <= RESET_VALUE;
    else       Output_q <= sel;
  end

endmodule

// File: tb/tb_mux_16b_two_input.sv
// Bench for mux_16b_two_input: vector table,
// scoreboard on the registered path, reset corners.
module tb_mux_16b_two_input;

  logic        clk;
  logic        reset;
  logic [15:0] A;
  logic [15:0] B;
  logic        Op;
  logic [15:0] Output;
  logic [15:0] Output_q;

  int total;
  int bad;

  logic [15:0] sbq[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[8];

  mux_16b_two_input dut (
    .clk(clk),
    .reset(reset),
    .A(A),
    .B(B),
    .Op(Op),
    .Output(Output),
    .Output_q(Output_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: act=%h req=%h", name, act, req);
    end
  endtask

  task automatic pop_check(input string name);
    logic [15:0] e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL %s: act=%h req=<empty queue>", name, Output_q);
    end else begin
      e = sbq.pop_front();
      if (Output_q !== e) begin
        bad++;
        $display("FAIL %s: act=%h req=%h", name, Output_q, e);
      end
    end
  endtask

  // Drive away from the edge, check comb path, then the registered copy.
  task automatic step(input string name,
                      input logic [15:0] a,
                      input logic [15:0] b,
                      input logic op,
                      input logic [15:0] exp);
    @(negedge clk);
    A  = a;
    B  = b;
    Op = op;
    #1;
    check({name, "_comb"}, Output, exp);
    sbq.push_back(exp);
    @(posedge clk);
    #1;
    pop_check({name, "_reg"});
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vt[0] = '{16'd57,    16'd10034, 1'b0, 16'd57};
    vt[1] = '{16'd57,    16'd10034, 1'b1, 16'd10034};
    vt[2] = '{16'hFFFF,  16'd10034, 1'b1, 16'd10034};
    vt[3] = '{16'hFFFF,  16'h0000,  1'b1, 16'h0000};
    vt[4] = '{16'hFFFF,  16'h0000,  1'b0, 16'hFFFF};
    vt[5] = '{16'hA5A5,  16'h5A5A,  1'b0, 16'hA5A5};
    vt[6] = '{16'hA5A5,  16'h5A5A,  1'b1, 16'h5A5A};
    vt[7] = '{16'h8001,  16'h7FFE,  1'b0, 16'h8001};

    reset = 1'b1;
    A  = 16'd57;
    B  = 16'd10034;
    Op = 1'b0;
    #100;
    check("rst_comb_a", Output, 16'd57);
    check("rst_q", Output_q, 16'h0000);
    Op = 1'b1;
    #20;
    check("rst_comb_b", Output, 16'd10034);
    check("rst_q_hold", Output_q, 16'h0000);

    @(negedge clk);
    reset = 1'b0;
    step("first_b", 16'd57, 16'd10034, 1'b1, 16'd10034);
    step("then_a", 16'd57, 16'd10034, 1'b0, 16'd57);

    for (int i = 0; i < 8; i++)
      step($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].op, vt[i].exp);

    // Async reset between edges: register clears, comb keeps tracking.
    step("pre_rst", 16'h1234, 16'hBEEF, 1'b1, 16'hBEEF);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_q", Output_q, 16'h0000);
    check("mid_rst_comb", Output, 16'hBEEF);
    A  = 16'h4321;
    Op = 1'b0;
    #1;
    check("mid_rst_comb2", Output, 16'h4321);
    @(posedge clk);
    #1;
    check("rst_held_q", Output_q, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    check("rel_q", Output_q, 16'h0000);
    step("rel_load", 16'h4321, 16'hBEEF, 1'b1, 16'hBEEF);

    // Extremes, select toggling every cycle.
    for (int i = 0; i < 8; i++)
      step($sformatf("tog%0d", i), 16'hFFFF, 16'h0000,
           (i % 2) == 1, ((i % 2) == 1) ? 16'h0000 : 16'hFFFF);

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: act=%0d req=0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
